// File: rtl/store_buffer.sv
// Posted-write store buffer between the core data port and data memory.
// Stores drain in order; loads merge pending bytes over the memory word.
//
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   cpu_addr/wdata        byte address and right-aligned store data
//   cpu_we/re/funct3      store/load request and access size
//   cpu_rdata             load result, sized and extended per funct3
//   stall                 store blocked by a full buffer
//   misalign_err          one-cycle pulse after a dropped misaligned store
//   empty                 no pending entries
//   mem_waddr/wdata/wstrb head entry presented to memory
//   mem_we/mem_wready     head valid / memory accepts head
//   mem_raddr/mem_rword   word-aligned load address / raw memory word
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    input  logic          cpu_we,
    input  logic          cpu_re,
    input  logic [2:0]    cpu_funct3,
    output logic [31:0]   cpu_rdata,
    output logic          stall,
    output logic          misalign_err,
    output logic          empty,
    output logic [AW-1:0] mem_waddr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wstrb,
    output logic          mem_we,
    input  logic          mem_wready,
    output logic [AW-1:0] mem_raddr,
    input  logic [31:0]   mem_rword
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Entry storage; not reset, validity comes from head/count only.
    logic [AW-3:0] waddr_q [DEPTH];
    logic [31:0]   data_q  [DEPTH];
    logic [3:0]    strb_q  [DEPTH];

    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;

    logic          full;
    logic          push;
    logic          pop;
    logic          misaligned;
    logic [31:0]   st_data;
    logic [3:0]    st_strb;
    logic [31:0]   merged;
    logic [15:0]   sh;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign stall = cpu_we & full;

    // Store encode: lane-align data and build byte enables.
    always_comb begin
        st_data    = cpu_wdata;
        st_strb    = 4'b1111;
        misaligned = 1'b0;
        case (cpu_funct3[1:0])
            2'b00: begin
                st_data = {4{cpu_wdata[7:0]}};
                st_strb = 4'b0001 << cpu_addr[1:0];
            end
            2'b01: begin
                st_data    = {2{cpu_wdata[15:0]}};
                st_strb    = cpu_addr[1] ? 4'b1100 : 4'b0011;
                misaligned = cpu_addr[0];
            end
            default: begin
                st_data    = cpu_wdata;
                st_strb    = 4'b1111;
                misaligned = (cpu_addr[1:0] != 2'b00);
            end
        endcase
    end

    // A full buffer refuses the store even when the head pops this cycle.
    assign push = cpu_we & ~full & ~misaligned;
    assign pop  = mem_we & mem_wready;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            misalign_err <= 1'b0;
        end else begin
            // Only flag once the store is actually presented, not while stalled.
            misalign_err <= cpu_we & ~full & misaligned;
            if (push) begin
                tail_q <= tail_q + 1'b1;
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
            if (push & ~pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop & ~push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            waddr_q[tail_q] <= cpu_addr[AW-1:2];
            data_q[tail_q]  <= st_data;
            strb_q[tail_q]  <= st_strb;
        end
    end

    assign mem_we    = ~empty;
    assign mem_waddr = {waddr_q[head_q], 2'b00};
    assign mem_wdata = data_q[head_q];
    assign mem_wstrb = strb_q[head_q];
    assign mem_raddr = {cpu_addr[AW-1:2], 2'b00};

    // Walk oldest to youngest so later matches overwrite earlier ones.
    always_comb begin
        logic [PW-1:0] idx;
        merged = mem_rword;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if ((CW'(k) < count_q) &&
                (waddr_q[idx] == cpu_addr[AW-1:2])) begin
                for (int i = 0; i < 4; i++) begin
                    if (strb_q[idx][i]) begin
                        merged[8*i +: 8] = data_q[idx][8*i +: 8];
                    end
                end
            end
        end
    end

    assign sh = 16'(merged >> {cpu_addr[1:0], 3'b000});

    always_comb begin
        cpu_rdata = 32'h0;
        if (cpu_re) begin
            case (cpu_funct3)
                3'b000:  cpu_rdata = {{24{sh[7]}}, sh[7:0]};
                3'b001:  cpu_rdata = {{16{sh[15]}}, sh};
                3'b010:  cpu_rdata = merged;
                3'b100:  cpu_rdata = {24'h0, sh[7:0]};
                3'b101:  cpu_rdata = {16'h0, sh};
                default: cpu_rdata = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: vector table plus hand-written
// sequences for fill/drain ordering and mid-drain reset.
module tb_store_buffer;

    logic        Clk;
    logic        Reset;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_we;
    logic        cpu_re;
    logic [2:0]  cpu_funct3;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        misalign_err;
    logic        empty;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_we;
    logic        mem_wready;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rword;

    int n_cmp = 0;
    int n_bad = 0;

    store_buffer #(.DEPTH(4), .AW(32)) dut (
        .Clk(Clk), .Reset(Reset),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_we(cpu_we), .cpu_re(cpu_re),
        .cpu_funct3(cpu_funct3), .cpu_rdata(cpu_rdata),
        .stall(stall), .misalign_err(misalign_err),
        .empty(empty), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_we(mem_we), .mem_wready(mem_wready),
        .mem_raddr(mem_raddr), .mem_rword(mem_rword)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        logic        we;
        logic        re;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wready;
        logic [31:0] rword;
        logic [31:0] e_rdata;
        logic        e_stall;
        logic        e_empty;
        logic        e_merr;
        logic [31:0] e_waddr;
        logic        cw;
        logic [31:0] e_wdata;
        logic [3:0]  e_wstrb;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic re, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic wr, input logic [31:0] rw,
                       input logic [31:0] e_rd, input logic e_st,
                       input logic e_em, input logic e_me,
                       input logic [31:0] e_wa, input logic cw,
                       input logic [31:0] e_wd, input logic [3:0] e_ws);
        vec_t v;
        v.we = we; v.re = re; v.f3 = f3; v.addr = addr;
        v.wdata = wd; v.wready = wr; v.rword = rw;
        v.e_rdata = e_rd; v.e_stall = e_st; v.e_empty = e_em;
        v.e_merr = e_me; v.e_waddr = e_wa; v.cw = cw;
        v.e_wdata = e_wd; v.e_wstrb = e_ws;
        vecs.push_back(v);
    endtask

    task automatic idle();
        cpu_we = 1'b0; cpu_re = 1'b0; cpu_funct3 = 3'b010;
        cpu_addr = 32'h0; cpu_wdata = 32'h0;
        mem_wready = 1'b0; mem_rword = 32'h0;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        idle();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
        #1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_merr", 32'(misalign_err), 32'd0);

        // we re f3 addr wdata wr rword | rdata stall empty merr waddr cw wd ws
        add(1,0,3'd2,32'h100,32'hDEADBEEF,0,0, 0,0,1,0,0, 0,0,0);
        add(0,1,3'd2,32'h100,0,0,0, 32'hDEADBEEF,0,0,0,32'h100,
            1,32'hDEADBEEF,4'hF);
        add(0,0,3'd2,0,0,1,0, 0,0,0,0,32'h100, 0,0,0);
        add(1,0,3'd0,32'h101,32'h123456AA,0,32'h11223344,
            0,0,1,0,0, 0,0,0);
        add(0,1,3'd2,32'h100,0,0,32'h11223344, 32'h1122AA44,0,0,0,32'h100,
            1,32'hAAAAAAAA,4'b0010);
        add(0,1,3'd0,32'h101,0,0,32'h11223344, 32'hFFFFFFAA,0,0,0,32'h100,
            0,0,0);
        add(0,1,3'd4,32'h101,0,0,32'h11223344, 32'h000000AA,0,0,0,32'h100,
            0,0,0);
        add(0,1,3'd1,32'h100,0,0,32'h11223344, 32'hFFFFAA44,0,0,0,32'h100,
            0,0,0);
        add(0,1,3'd5,32'h102,0,0,32'h11223344, 32'h00001122,0,0,0,32'h100,
            0,0,0);
        add(0,1,3'd3,32'h100,0,0,32'h11223344, 0,0,0,0,32'h100, 0,0,0);
        add(0,0,3'd2,0,0,1,0, 0,0,0,0,32'h100, 0,0,0);
        add(1,0,3'd2,32'h200,32'h1,0,0, 0,0,1,0,0, 0,0,0);
        add(1,0,3'd2,32'h200,32'h2,0,0, 0,0,0,0,32'h200, 0,0,0);
        add(0,1,3'd2,32'h200,0,0,32'hFFFFFFFF, 32'h2,0,0,0,32'h200, 0,0,0);
        add(1,0,3'd1,32'h202,32'h0000BEEF,0,0, 0,0,0,0,32'h200, 0,0,0);
        add(0,1,3'd2,32'h200,0,0,32'hFFFFFFFF, 32'hBEEF0002,0,0,0,32'h200,
            0,0,0);
        add(1,1,3'd0,32'h203,32'h55,0,32'hFFFFFFFF, 32'hFFFFFFBE,0,0,0,
            32'h200, 0,0,0);
        add(1,1,3'd0,32'h203,32'h77,0,32'hFFFFFFFF, 32'h55,1,0,0,32'h200,
            0,0,0);
        add(1,1,3'd0,32'h203,32'h77,1,32'hFFFFFFFF, 32'h55,1,0,0,32'h200,
            1,32'h1,4'hF);
        add(0,0,3'd2,0,0,1,0, 0,0,0,0,32'h200, 1,32'h2,4'hF);
        add(0,0,3'd2,0,0,1,0, 0,0,0,0,32'h200, 1,32'hBEEFBEEF,4'b1100);
        add(0,0,3'd2,0,0,1,0, 0,0,0,0,32'h200, 1,32'h55555555,4'b1000);
        add(1,0,3'd2,32'h102,32'h9,0,0, 0,0,1,0,0, 0,0,0);
        add(0,0,3'd2,0,0,0,0, 0,0,1,1,0, 0,0,0);
        add(1,0,3'd1,32'h101,32'h9,0,0, 0,0,1,0,0, 0,0,0);
        add(0,0,3'd2,0,0,0,0, 0,0,1,1,0, 0,0,0);
        add(1,0,3'd2,32'h10,32'hA,0,0, 0,0,1,0,0, 0,0,0);
        add(1,0,3'd2,32'h14,32'hB,0,0, 0,0,0,0,32'h10, 0,0,0);
        add(1,0,3'd2,32'h18,32'hC,1,0, 0,0,0,0,32'h10, 1,32'hA,4'hF);
        add(0,0,3'd2,0,0,0,0, 0,0,0,0,32'h14, 0,0,0);
        add(0,0,3'd2,0,0,1,0, 0,0,0,0,32'h14, 1,32'hB,4'hF);
        add(0,0,3'd2,0,0,1,0, 0,0,0,0,32'h18, 1,32'hC,4'hF);
        add(0,0,3'd2,0,0,0,0, 0,0,1,0,0, 0,0,0);

        foreach (vecs[n]) begin
            vec_t v;
            string tag;
            v = vecs[n];
            tag = $sformatf("v%0d", n);
            cpu_we = v.we; cpu_re = v.re; cpu_funct3 = v.f3;
            cpu_addr = v.addr; cpu_wdata = v.wdata;
            mem_wready = v.wready; mem_rword = v.rword;
            #1;
            chk({tag, "_rdata"}, cpu_rdata, v.e_rdata);
            chk({tag, "_stall"}, 32'(stall), 32'(v.e_stall));
            chk({tag, "_empty"}, 32'(empty), 32'(v.e_empty));
            chk({tag, "_mem_we"}, 32'(mem_we), 32'(!v.e_empty));
            chk({tag, "_merr"}, 32'(misalign_err), 32'(v.e_merr));
            if (!v.e_empty)
                chk({tag, "_waddr"}, mem_waddr, v.e_waddr);
            if (v.re)
                chk({tag, "_raddr"}, mem_raddr, {v.addr[31:2], 2'b00});
            if (v.cw) begin
                chk({tag, "_wdata"}, mem_wdata, v.e_wdata);
                chk({tag, "_wstrb"}, 32'(mem_wstrb), 32'(v.e_wstrb));
            end
            step();
        end
        idle();

        // Fill to DEPTH, stall on the fifth store, then drain in order.
        for (int k = 0; k < 4; k++) begin
            cpu_we = 1'b1; cpu_funct3 = 3'b010;
            cpu_addr = 32'(4 * k); cpu_wdata = 32'h1000 + 32'(k);
            #1;
            chk($sformatf("fill%0d_stall", k), 32'(stall), 32'd0);
            step();
        end
        cpu_addr = 32'h10; cpu_wdata = 32'h2000;
        #1;
        chk("full_stall", 32'(stall), 32'd1);
        step();
        chk("full_stall2", 32'(stall), 32'd1);
        cpu_we = 1'b0;
        mem_wready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("drain%0d_waddr", k), mem_waddr, 32'(4 * k));
            chk($sformatf("drain%0d_wdata", k), mem_wdata,
                32'h1000 + 32'(k));
            chk($sformatf("drain%0d_we", k), 32'(mem_we), 32'd1);
            step();
        end
        chk("drain_empty", 32'(empty), 32'd1);
        idle();

        // Reset with three entries pending and the memory ready.
        for (int k = 0; k < 3; k++) begin
            cpu_we = 1'b1; cpu_funct3 = 3'b010;
            cpu_addr = 32'h400 + 32'(4 * k);
            cpu_wdata = 32'hCAFE0000 + 32'(k);
            step();
        end
        idle();
        #1;
        chk("pre_rst_empty", 32'(empty), 32'd0);
        mem_wready = 1'b1;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        #1;
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_mem_we", 32'(mem_we), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        cpu_re = 1'b1; cpu_funct3 = 3'b010;
        cpu_addr = 32'h404; mem_rword = 32'h12345678;
        #1;
        chk("midrst_load", cpu_rdata, 32'h12345678);
        step();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
